// File: rtl/rand_pkg.sv
// Shared definitions for the 6-bit pseudo-random generator and its receive-side checker.
package rand_pkg;

  localparam int LFSR_W = 6;
  localparam int TAP_A  = 5;
  localparam int TAP_B  = 3;
  localparam int TAP_C  = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    TRACK = 2'd2,
    LOST  = 2'd3
  } state_t;

  // Feedback bit shared by the generator and the predictor.
  function automatic logic lfsr_fb(input logic [LFSR_W-1:0] s);
    return s[TAP_A] ^ s[TAP_B] ^ s[TAP_C];
  endfunction

endpackage

// File: rtl/rand_predictor.sv
// Predictor register: loads received bits while seeding, free-runs on its own feedback while tracking.
module rand_predictor
  import rand_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load_en,
  input  logic              track_en,
  input  logic              bit_in,
  output logic              pred,
  output logic [LFSR_W-1:0] pred_state
);

  assign pred = lfsr_fb(pred_state);

  // Tracking shifts in the predicted bit, so a corrupted input never pollutes the register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pred_state <= '0;
    end else if (clear) begin
      pred_state <= '0;
    end else if (load_en) begin
      pred_state <= {pred_state[LFSR_W-2:0], bit_in};
    end else if (track_en) begin
      pred_state <= {pred_state[LFSR_W-2:0], pred};
    end
  end

endmodule

// File: rtl/rand_checker.sv
// Receive-side checker: self-seeds from the stream, predicts each bit, counts errors and relocks.
module rand_checker
  import rand_pkg::*;
#(
  parameter int LOSS_THRESH = 4,
  parameter int WINDOW      = 16,
  parameter int ERR_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              bit_valid,
  input  logic              bit_in,
  output logic              locked,
  output logic              err_pulse,
  output logic              relock,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [LFSR_W-1:0] pred_state
);

  localparam int WIN_W   = $clog2(WINDOW);
  localparam int WERR_W  = $clog2(WINDOW + 1);
  localparam int FILL_W  = $clog2(LFSR_W);

  state_t              state;
  state_t              state_next;
  logic [FILL_W-1:0]   fill_cnt;
  logic [WIN_W-1:0]    win_cnt;
  logic [WERR_W-1:0]   win_err;
  logic                pred;
  logic [LFSR_W-1:0]   shifted;
  logic                mismatch;
  logic                thresh_hit;
  logic                win_wrap;
  logic                fill_last;
  logic                pr_clear;
  logic                pr_load;
  logic                pr_track;
  logic                relock_next;
  logic                err_next;

  assign shifted    = {pred_state[LFSR_W-2:0], bit_in};
  assign mismatch   = bit_in ^ pred;
  assign thresh_hit = (win_err == WERR_W'(LOSS_THRESH - 1));
  assign win_wrap   = (win_cnt == WIN_W'(WINDOW - 1));
  assign fill_last  = (fill_cnt == FILL_W'(LFSR_W - 1));

  rand_predictor u_predictor (
    .clk        (clk),
    .rst        (rst),
    .clear      (pr_clear),
    .load_en    (pr_load),
    .track_en   (pr_track),
    .bit_in     (bit_in),
    .pred       (pred),
    .pred_state (pred_state)
  );

  // start overrides everything, including a bit presented in the same cycle.
  always_comb begin
    state_next  = state;
    pr_clear    = 1'b0;
    pr_load     = 1'b0;
    pr_track    = 1'b0;
    relock_next = 1'b0;
    err_next    = 1'b0;
    if (start) begin
      state_next = FILL;
      pr_clear   = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          state_next = IDLE;
        end
        FILL: begin
          if (bit_valid) begin
            pr_load = 1'b1;
            if (fill_last && (shifted != '0)) begin
              state_next = TRACK;
            end
          end
        end
        TRACK: begin
          if (bit_valid) begin
            pr_track = 1'b1;
            if (mismatch) begin
              err_next = 1'b1;
              if (thresh_hit) begin
                state_next = LOST;
              end
            end
          end
        end
        LOST: begin
          state_next  = FILL;
          pr_clear    = 1'b1;
          relock_next = 1'b1;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // The error window restarts every WINDOW tracked bits; reaching the threshold beats the wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      relock    <= 1'b0;
      err_cnt   <= '0;
      fill_cnt  <= '0;
      win_cnt   <= '0;
      win_err   <= '0;
    end else begin
      state     <= state_next;
      locked    <= (state_next == TRACK);
      err_pulse <= err_next;
      relock    <= relock_next;
      if (start) begin
        err_cnt  <= '0;
        fill_cnt <= '0;
        win_cnt  <= '0;
        win_err  <= '0;
      end else begin
        case (state)
          FILL: begin
            if (bit_valid) begin
              fill_cnt <= fill_last ? '0 : fill_cnt + 1'b1;
            end
          end
          TRACK: begin
            if (bit_valid) begin
              win_cnt <= win_cnt + 1'b1;
              if (err_next && (err_cnt != {ERR_W{1'b1}})) begin
                err_cnt <= err_cnt + 1'b1;
              end
              if (err_next && thresh_hit) begin
                win_err <= win_err + 1'b1;
              end else if (win_wrap) begin
                win_err <= '0;
              end else if (err_next) begin
                win_err <= win_err + 1'b1;
              end
            end
          end
          LOST: begin
            fill_cnt <= '0;
            win_cnt  <= '0;
            win_err  <= '0;
          end
          default: begin
            fill_cnt <= fill_cnt;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rand_checker.sv
// Self-checking bench for rand_checker: vector table, hand-written corner sequences, random stream vs model.
module tb_rand_checker;

  localparam int LOSS_THRESH = 4;
  localparam int WINDOW      = 16;
  localparam int ERR_MAX     = 255;

  localparam int M_IDLE  = 0;
  localparam int M_FILL  = 1;
  localparam int M_TRACK = 2;
  localparam int M_LOST  = 3;

  logic       clk;
  logic       rst;
  logic       start;
  logic       bit_valid;
  logic       bit_in;
  logic       locked;
  logic       err_pulse;
  logic       relock;
  logic [7:0] err_cnt;
  logic [5:0] pred_state;

  logic       s_locked;
  logic       s_err_pulse;
  logic       s_relock;
  logic [1:0] s_err_cnt;
  logic [5:0] s_pred_state;

  int n_cmp;
  int n_fail;

  rand_checker #(.LOSS_THRESH(LOSS_THRESH), .WINDOW(WINDOW), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .bit_valid(bit_valid), .bit_in(bit_in),
    .locked(locked), .err_pulse(err_pulse), .relock(relock),
    .err_cnt(err_cnt), .pred_state(pred_state)
  );

  rand_checker #(.LOSS_THRESH(16), .WINDOW(16), .ERR_W(2)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .bit_valid(bit_valid), .bit_in(bit_in),
    .locked(s_locked), .err_pulse(s_err_pulse), .relock(s_relock),
    .err_cnt(s_err_cnt), .pred_state(s_pred_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: received/predicted bit history plus plain counters.
  int m_mode;
  int m_nfill;
  int m_wbits;
  int m_werrs;
  int m_errs;
  bit m_pulse;
  bit m_relock;
  bit hist[$];

  function automatic bit h(input int k);
    if (hist.size() >= k) return hist[hist.size() - k];
    return 1'b0;
  endfunction

  function automatic bit model_next_bit();
    return h(6) ^ h(4) ^ h(2);
  endfunction

  function automatic logic [5:0] model_pred_state();
    logic [5:0] v;
    v = '0;
    for (int i = 6; i >= 1; i--) v = {v[4:0], h(i)};
    return v;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_nfill = 0; m_wbits = 0; m_werrs = 0; m_errs = 0;
    m_pulse = 0; m_relock = 0;
    hist.delete();
  endtask

  task automatic model_push(input bit b);
    hist.push_back(b);
    if (hist.size() > 6) void'(hist.pop_front());
  endtask

  task automatic model_step(input bit st, input bit bv, input bit bi);
    bit p;
    m_pulse = 0;
    m_relock = 0;
    if (st) begin
      m_mode = M_FILL; m_nfill = 0; m_wbits = 0; m_werrs = 0; m_errs = 0;
      hist.delete();
    end else if (m_mode == M_FILL) begin
      if (bv) begin
        model_push(bi);
        m_nfill++;
        if (m_nfill == 6) begin
          m_nfill = 0;
          if (model_pred_state() != 6'd0) m_mode = M_TRACK;
        end
      end
    end else if (m_mode == M_TRACK) begin
      if (bv) begin
        p = model_next_bit();
        model_push(p);
        m_wbits++;
        if (bi != p) begin
          m_pulse = 1;
          if (m_errs < ERR_MAX) m_errs++;
          m_werrs++;
          if (m_werrs == LOSS_THRESH) m_mode = M_LOST;
        end
        if (m_mode != M_LOST && m_wbits == WINDOW) begin
          m_wbits = 0;
          m_werrs = 0;
        end
      end
    end else if (m_mode == M_LOST) begin
      m_mode = M_FILL; m_nfill = 0; m_wbits = 0; m_werrs = 0;
      hist.delete();
      m_relock = 1;
    end
  endtask

  task automatic cmp(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    cmp("locked", int'(locked), int'(m_mode == M_TRACK));
    cmp("err_pulse", int'(err_pulse), int'(m_pulse));
    cmp("relock", int'(relock), int'(m_relock));
    cmp("err_cnt", int'(err_cnt), m_errs);
    cmp("pred_state", int'(pred_state), int'(model_pred_state()));
  endtask

  task automatic applyStimulus(input bit st, input bit bv, input bit bi);
    start = st; bit_valid = bv; bit_in = bi;
    @(posedge clk);
    #1;
    model_step(st, bv, bi);
    checkOutput();
  endtask

  task automatic send_seed(input logic [5:0] s);
    for (int i = 5; i >= 0; i--) applyStimulus(1'b0, 1'b1, s[i]);
  endtask

  typedef struct {
    bit         st, bv, bi;
    bit         e_locked, e_pulse, e_relock;
    int         e_err;
    logic [5:0] e_pred;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input bit st, input bit bv, input bit bi, input bit el,
                         input bit ep, input int ee, input logic [5:0] epr);
    vec_t v;
    v.st = st; v.bv = bv; v.bi = bi;
    v.e_locked = el; v.e_pulse = ep; v.e_relock = 1'b0; v.e_err = ee; v.e_pred = epr;
    vecs.push_back(v);
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    rst = 1'b1; start = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
    model_reset();

    // clean lock, then restart with a coincident bit and a single error
    add_vec(0, 1, 1, 0, 0, 0, 6'h00);
    add_vec(1, 0, 0, 0, 0, 0, 6'h00);
    add_vec(0, 1, 1, 0, 0, 0, 6'h01);
    add_vec(0, 1, 0, 0, 0, 0, 6'h02);
    add_vec(0, 1, 1, 0, 0, 0, 6'h05);
    add_vec(0, 1, 1, 0, 0, 0, 6'h0B);
    add_vec(0, 1, 0, 0, 0, 0, 6'h16);
    add_vec(0, 1, 1, 1, 0, 0, 6'h2D);
    add_vec(0, 1, 0, 1, 0, 0, 6'h1A);
    add_vec(0, 1, 0, 1, 0, 0, 6'h34);
    add_vec(0, 1, 1, 1, 0, 0, 6'h29);
    add_vec(0, 1, 0, 1, 0, 0, 6'h12);
    add_vec(0, 0, 1, 1, 0, 0, 6'h12);
    add_vec(1, 1, 1, 0, 0, 0, 6'h00);
    add_vec(0, 1, 1, 0, 0, 0, 6'h01);
    add_vec(0, 1, 0, 0, 0, 0, 6'h02);
    add_vec(0, 1, 1, 0, 0, 0, 6'h05);
    add_vec(0, 1, 1, 0, 0, 0, 6'h0B);
    add_vec(0, 1, 0, 0, 0, 0, 6'h16);
    add_vec(0, 1, 1, 1, 0, 0, 6'h2D);
    add_vec(0, 1, 0, 1, 0, 0, 6'h1A);
    add_vec(0, 1, 0, 1, 0, 0, 6'h34);
    add_vec(0, 1, 0, 1, 1, 1, 6'h29);
    add_vec(0, 1, 0, 1, 0, 1, 6'h12);
    add_vec(0, 1, 1, 1, 0, 1, 6'h25);
    add_vec(0, 1, 1, 1, 0, 1, 6'h0B);
    add_vec(0, 1, 0, 1, 0, 1, 6'h16);
    add_vec(0, 1, 1, 1, 0, 1, 6'h2D);

    repeat (2) @(posedge clk);
    #1;
    checkOutput();
    cmp("reset sat err_cnt", int'(s_err_cnt), 0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].st, vecs[i].bv, vecs[i].bi);
      cmp($sformatf("vec%0d locked", i), int'(locked), int'(vecs[i].e_locked));
      cmp($sformatf("vec%0d err_pulse", i), int'(err_pulse), int'(vecs[i].e_pulse));
      cmp($sformatf("vec%0d relock", i), int'(relock), int'(vecs[i].e_relock));
      cmp($sformatf("vec%0d err_cnt", i), int'(err_cnt), vecs[i].e_err);
      cmp($sformatf("vec%0d pred", i), int'(pred_state), int'(vecs[i].e_pred));
    end

    $display("[TB] loss and relock");
    applyStimulus(1'b1, 1'b0, 1'b0);
    send_seed(6'h2D);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, ~model_next_bit());
    cmp("lost locked", int'(locked), 0);
    cmp("lost err_cnt", int'(err_cnt), 4);
    cmp("lost relock early", int'(relock), 0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    cmp("relock pulse", int'(relock), 1);
    cmp("relock pred", int'(pred_state), 0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    cmp("relock single", int'(relock), 0);
    send_seed(6'h2D);
    cmp("relocked", int'(locked), 1);
    cmp("relocked err_cnt", int'(err_cnt), 4);

    $display("[TB] zero seed");
    applyStimulus(1'b1, 1'b0, 1'b0);
    send_seed(6'h00);
    cmp("zero seed locked", int'(locked), 0);
    send_seed(6'h01);
    cmp("seed1 locked", int'(locked), 1);
    cmp("seed1 pred", int'(pred_state), 6'h01);

    $display("[TB] saturation");
    applyStimulus(1'b1, 1'b0, 1'b0);
    send_seed(6'h2D);
    applyStimulus(1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    cmp("sat err_cnt 3", int'(s_err_cnt), 3);
    applyStimulus(1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    cmp("sat err_cnt held", int'(s_err_cnt), 3);
    cmp("sat locked", int'(s_locked), 1);

    $display("[TB] reset mid-track, start with coincident bit");
    applyStimulus(1'b1, 1'b0, 1'b0);
    send_seed(6'h2D);
    applyStimulus(1'b0, 1'b1, 1'b0);
    start = 1'b0; bit_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    cmp("async rst locked", int'(locked), 0);
    cmp("async rst pred", int'(pred_state), 0);
    cmp("async rst err_cnt", int'(err_cnt), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1);
    cmp("idle after rst pred", int'(pred_state), 0);
    applyStimulus(1'b1, 1'b1, 1'b1);
    cmp("coincident pred", int'(pred_state), 0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    cmp("5th bit not locked", int'(locked), 0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    cmp("6th bit locked", int'(locked), 1);
    cmp("6th bit pred", int'(pred_state), 6'h2D);

    $display("[TB] random stream");
    for (int i = 0; i < 1500; i++) begin
      bit st, bv, bi;
      st = ($urandom_range(0, 99) == 0);
      bv = ($urandom_range(0, 3) != 0);
      if (m_mode == M_TRACK)
        bi = ($urandom_range(0, 9) == 0) ? ~model_next_bit() : model_next_bit();
      else
        bi = 1'($urandom_range(0, 1));
      applyStimulus(st, bv, bi);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
